// File: rtl/add_sub_pkg.sv
// Shared constants and the inter-stage token for the 36-bit sliced subtract pipeline.
package add_sub_pkg;

    localparam int SLICE_W = 12;
    localparam int N_SLICE = 3;
    localparam int DATA_W  = SLICE_W * N_SLICE;

    localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Full-width fields: slices below the current stage hold resolved d bits,
    // slices above it still hold raw operands.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] a_hi;
        logic [DATA_W-1:0] b_hi;
        logic [DATA_W-1:0] d_lo;
        logic              borrow;
    } stage_tok_t;

endpackage

// File: rtl/sub_slice_12bits.sv
// Combinational 12-bit slice subtract d = a - b - bin, built as a + ~b + ~bin
// with a sum-of-products carry lookahead.
module sub_slice_12bits
    import add_sub_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bin,
    output logic [SLICE_W-1:0] d,
    output logic               bout
);
    logic [SLICE_W-1:0] p, g;
    logic [SLICE_W:0]   c;

    assign p = a ^ ~b;
    assign g = a & ~b;

    always_comb begin
        logic pp;
        pp = 1'b1;
        c = '0;
        c[0] = ~bin;
        for (int i = 0; i < SLICE_W; i++) begin
            pp = 1'b1;
            for (int j = i; j >= 0; j--) begin
                c[i+1] = c[i+1] | (g[j] & pp);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & c[0]);
        end
    end

    assign d    = p ^ c[SLICE_W-1:0];
    assign bout = ~c[SLICE_W];

endmodule

// File: rtl/sub_pipe_36bits.sv
// Three-stage 36-bit subtractor, one 12-bit slice resolved per stage, valid/ready throughout.
// Optional SUB_PIPE_SAT_EN clamps d to SMAX/SMIN on signed overflow.
module sub_pipe_36bits
    import add_sub_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] d,
    output logic              bout,
    output logic              ovf,
    output logic              zero
);
    localparam int LAST = N_SLICE - 1;

    stage_tok_t [N_SLICE-1:0]        src, nxt;
    stage_tok_t [LAST-1:0]           tok;
    logic [N_SLICE-1:0][SLICE_W-1:0] slice_d;
    logic [N_SLICE-1:0]              slice_bo;
    logic [N_SLICE:0]                vld_pipe, rdy;
    logic [DATA_W-1:0]               d_raw, d_fin;
    logic                            ovf_raw, a_msb, b_msb;
    logic                            unused_last;

    always_comb begin
        src = '0;
        src[0].valid  = in_valid;
        src[0].a_hi   = a;
        src[0].b_hi   = b;
        src[0].borrow = bin;
        for (int k = 1; k < N_SLICE; k++) src[k] = tok[k-1];
    end

    for (genvar k = 0; k < N_SLICE; k++) begin : g_slice
        sub_slice_12bits u_slice (
            .a    (src[k].a_hi[k*SLICE_W +: SLICE_W]),
            .b    (src[k].b_hi[k*SLICE_W +: SLICE_W]),
            .bin  (src[k].borrow),
            .d    (slice_d[k]),
            .bout (slice_bo[k])
        );
    end

    always_comb begin
        nxt = src;
        for (int k = 0; k < N_SLICE; k++) begin
            nxt[k].d_lo[k*SLICE_W +: SLICE_W] = slice_d[k];
            nxt[k].borrow                     = slice_bo[k];
        end
    end

    // vld_pipe[k] is the token offered to stage k; the ready chain walks back from the consumer.
    always_comb begin
        vld_pipe = '0;
        vld_pipe[0] = in_valid;
        for (int k = 0; k < LAST; k++) vld_pipe[k+1] = tok[k].valid;
        vld_pipe[N_SLICE] = out_valid;
        rdy = '0;
        rdy[N_SLICE] = out_ready;
        for (int k = N_SLICE - 1; k >= 0; k--) rdy[k] = !vld_pipe[k+1] || rdy[k+1];
    end

    assign in_ready = rdy[0];

    assign d_raw   = nxt[LAST].d_lo;
    assign a_msb   = nxt[LAST].a_hi[DATA_W-1];
    assign b_msb   = nxt[LAST].b_hi[DATA_W-1];
    assign ovf_raw = (a_msb != b_msb) && (d_raw[DATA_W-1] != a_msb);

`ifdef SUB_PIPE_SAT_EN
    assign d_fin = ovf_raw ? (a_msb ? SMIN : SMAX) : d_raw;
`else
    assign d_fin = d_raw;
`endif

    assign unused_last = ^{nxt[LAST].valid, nxt[LAST].a_hi[DATA_W-2:0], nxt[LAST].b_hi[DATA_W-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok       <= '0;
            out_valid <= 1'b0;
            d         <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            for (int k = 0; k < LAST; k++) begin
                if (rdy[k]) begin
                    if (vld_pipe[k]) tok[k] <= nxt[k];
                    else             tok[k].valid <= 1'b0;
                end
            end
            if (rdy[LAST]) begin
                out_valid <= vld_pipe[LAST];
                if (vld_pipe[LAST]) begin
                    d    <= d_fin;
                    bout <= nxt[LAST].borrow;
                    ovf  <= ovf_raw;
                    zero <= (d_fin == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_sub_pipe_36bits.sv
// Directed vector table, stall/reset sequences and a random stream against an a-b-bin reference.
module tb_sub_pipe_36bits;
    import add_sub_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
    logic [35:0] a = '0, b = '0;
    logic        in_ready, out_valid, bout, ovf, zero;
    logic [35:0] d;

    int checks = 0, failures = 0;

    sub_pipe_36bits dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bout(bout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

`ifdef SUB_PIPE_SAT_EN
    localparam logic [35:0] V_POS_OVF = 36'h7_FFFF_FFFF;
    localparam logic [35:0] V_NEG_OVF = 36'h8_0000_0000;
`else
    localparam logic [35:0] V_POS_OVF = 36'h8_0000_0000;
    localparam logic [35:0] V_NEG_OVF = 36'h7_FFFF_FFFF;
`endif

    typedef struct {
        logic [35:0] a;
        logic [35:0] b;
        logic        bin;
        logic [35:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [38:0] model(input logic [35:0] ma, input logic [35:0] mb, input logic mbin);
        logic [36:0] r;
        logic [35:0] md;
        logic        mo;
        r  = {1'b0, ma} - {1'b0, mb} - {36'd0, mbin};
        md = r[35:0];
        mo = (ma[35] != mb[35]) && (md[35] != ma[35]);
`ifdef SUB_PIPE_SAT_EN
        if (mo) md = ma[35] ? 36'h8_0000_0000 : 36'h7_FFFF_FFFF;
`endif
        return {r[36], mo, (md == 36'd0), md};
    endfunction

    // Single token into an idle pipe; returns the edge count until out_valid.
    task automatic run_one(input logic [35:0] ta, input logic [35:0] tb_, input logic tbin, output int lat);
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb_; bin = tbin; out_ready = 1'b1;
        #1 chk("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 10);
    endtask

    task automatic run_stream(input int n, input bit rnd);
        logic [38:0] expq[$];
        logic [38:0] prev_out;
        logic [35:0] na, nb;
        logic        nbin;
        int          sent, recv, cyc;
        bit          prev_stall, saw_full, have;
        sent = 0; recv = 0; cyc = 0;
        prev_stall = 0; saw_full = 0; have = 0;
        prev_out = '0; na = '0; nb = '0; nbin = 1'b0;
        while (recv < n && cyc < n * 20 + 50) begin
            @(negedge clk);
            cyc++;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 5 && cyc < 10);
            if (sent < n) begin
                if (!have) begin
                    if (rnd) begin
                        na   = {4'($urandom_range(0, 15)), $urandom()};
                        nb   = ($urandom_range(0, 7) == 0) ? na : {4'($urandom_range(0, 15)), $urandom()};
                        nbin = 1'($urandom_range(0, 1));
                    end else begin
                        na   = 36'h1_2345_6789 * 36'(sent + 1);
                        nb   = 36'h0_9876_5432 + 36'(sent);
                        nbin = sent[0];
                    end
                    have = 1;
                end
                in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            a = na; b = nb; bin = nbin;
            #1;
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'({bout, ovf, zero, d}), 64'(prev_out));
            end
            if (!in_ready && !saw_full) begin
                chk("full_count", 64'(sent - recv), 64'd3);
                saw_full = 1;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("stream_extra", 64'd1, 64'd0);
                else chk("stream_out", 64'({bout, ovf, zero, d}), 64'(expq.pop_front()));
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {bout, ovf, zero, d};
            if (in_valid && in_ready) begin
                expq.push_back(model(na, nb, nbin));
                sent++;
                have = 0;
            end
        end
        in_valid = 1'b0;
        chk("stream_count", 64'(recv), 64'(n));
        if (!rnd) chk("stall_in_ready_low", 64'(saw_full), 64'd1);
    endtask

    initial begin
        int lat;
        vecs[0] = '{36'h0_0000_0005, 36'h0_0000_0003, 1'b0, 36'h0_0000_0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{36'h0_0000_0000, 36'h0_0000_0001, 1'b0, 36'hF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{36'h0_0000_0123, 36'h0_0000_0122, 1'b1, 36'h0_0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{36'h7_FFFF_FFFF, 36'hF_FFFF_FFFF, 1'b0, V_POS_OVF,       1'b1, 1'b1, 1'b0};
        vecs[4] = '{36'h0_0100_0000, 36'h0_0000_0001, 1'b0, 36'h0_00FF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{36'h9_ABCD_1234, 36'h9_ABCD_1234, 1'b0, 36'h0_0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{36'h8_0000_0000, 36'h0_0000_0001, 1'b0, V_NEG_OVF,       1'b0, 1'b1, 1'b0};
        vecs[7] = '{36'h0_0000_0000, 36'h0_0000_0000, 1'b1, 36'hF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{36'h0_0000_1000, 36'h0_0000_0FFF, 1'b1, 36'h0_0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{36'hF_FFFF_FFFF, 36'h8_0000_0000, 1'b0, 36'h7_FFFF_FFFF, 1'b0, 1'b0, 1'b0};

        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_d", 64'(d), 64'd0);
        chk("rst_flags", 64'({bout, ovf, zero}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_one(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
            chk($sformatf("vec%0d_d", i), 64'(d), 64'(vecs[i].d));
            chk($sformatf("vec%0d_bout", i), 64'(bout), 64'(vecs[i].bout));
            chk($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].ovf));
            chk($sformatf("vec%0d_zero", i), 64'(zero), 64'(vecs[i].zero));
        end

        run_stream(8, 1'b0);

        // Fill the pipe against a stalled consumer, then reset with three tokens in flight.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        a = 36'h0_0000_0077; b = 36'h0_0000_0011; bin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full_out_valid", 64'(out_valid), 64'd1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_d", 64'(d), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_one(36'h0_0000_0040, 36'h0_0000_0001, 1'b1, lat);
        chk("postrst_latency", 64'(lat), 64'd3);
        chk("postrst_d", 64'(d), 64'h3E);

        run_stream(300, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
